// File: rtl/sdram_axi_arbiter.sv
// Purpose : N-port AXI4 INCR-burst arbiter in front of the single-port SDRAM AXI controller.
//           Independent round-robin read and write arbiters; one outstanding burst per direction.
// Latency : 1-cycle arbitration (request seen in idle -> m_*valid_o next cycle); data/resp paths combinational.
// Backpressure: the grant is held until the burst completes; ready/valid pass straight through for the granted port only.
// Ports   : clk_i/rst_i (async active-low); s_* = NUM_PORTS upstream AXI masters (port p at slice p of each bus);
//           m_* = single downstream AXI port. Responses are steered by the registered grant, not by ID.
// Option  : define SDRAM_ARB_PRIO_EN to give port 0 fixed top priority (rr among ports 1..N-1 only).
module sdram_axi_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int ID_W      = 4,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // upstream write address / data / response
  input  logic [NUM_PORTS-1:0]        s_awvalid_i,
  output logic [NUM_PORTS-1:0]        s_awready_o,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_awaddr_i,
  input  logic [NUM_PORTS*ID_W-1:0]   s_awid_i,
  input  logic [NUM_PORTS*8-1:0]      s_awlen_i,
  input  logic [NUM_PORTS-1:0]        s_wvalid_i,
  output logic [NUM_PORTS-1:0]        s_wready_o,
  input  logic [NUM_PORTS*DATA_W-1:0] s_wdata_i,
  input  logic [NUM_PORTS*STRB_W-1:0] s_wstrb_i,
  input  logic [NUM_PORTS-1:0]        s_wlast_i,
  output logic [NUM_PORTS-1:0]        s_bvalid_o,
  input  logic [NUM_PORTS-1:0]        s_bready_i,
  output logic [1:0]                  s_bresp_o,
  output logic [ID_W-1:0]             s_bid_o,
  // upstream read address / data
  input  logic [NUM_PORTS-1:0]        s_arvalid_i,
  output logic [NUM_PORTS-1:0]        s_arready_o,
  input  logic [NUM_PORTS*ADDR_W-1:0] s_araddr_i,
  input  logic [NUM_PORTS*ID_W-1:0]   s_arid_i,
  input  logic [NUM_PORTS*8-1:0]      s_arlen_i,
  output logic [NUM_PORTS-1:0]        s_rvalid_o,
  input  logic [NUM_PORTS-1:0]        s_rready_i,
  output logic [DATA_W-1:0]           s_rdata_o,
  output logic [1:0]                  s_rresp_o,
  output logic [ID_W-1:0]             s_rid_o,
  output logic                        s_rlast_o,
  // downstream port to the SDRAM controller
  output logic                        m_awvalid_o,
  input  logic                        m_awready_i,
  output logic [ADDR_W-1:0]           m_awaddr_o,
  output logic [ID_W-1:0]             m_awid_o,
  output logic [7:0]                  m_awlen_o,
  output logic [1:0]                  m_awburst_o,
  output logic                        m_wvalid_o,
  input  logic                        m_wready_i,
  output logic [DATA_W-1:0]           m_wdata_o,
  output logic [STRB_W-1:0]           m_wstrb_o,
  output logic                        m_wlast_o,
  input  logic                        m_bvalid_i,
  output logic                        m_bready_o,
  input  logic [1:0]                  m_bresp_i,
  input  logic [ID_W-1:0]             m_bid_i,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  output logic [ADDR_W-1:0]           m_araddr_o,
  output logic [ID_W-1:0]             m_arid_o,
  output logic [7:0]                  m_arlen_o,
  output logic [1:0]                  m_arburst_o,
  input  logic                        m_rvalid_i,
  output logic                        m_rready_o,
  input  logic [DATA_W-1:0]           m_rdata_i,
  input  logic [1:0]                  m_rresp_i,
  input  logic [ID_W-1:0]             m_rid_i,
  input  logic                        m_rlast_i
);

  localparam int GW = $clog2(NUM_PORTS);

`ifdef SDRAM_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;

  // First requester found scanning cyclically from ptr. With priority enabled,
  // port 0 wins outright and is skipped by the rotating scan.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [GW-1:0]        ptr);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    if (PRIO_EN && req[0]) found = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr) + i) % NUM_PORTS;
      if (!found && req[idx] && !(PRIO_EN && idx == 0)) begin
        sel   = GW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Pointer after a completed burst: one past the winner. Port-0 wins under
  // priority leave it untouched, and the wrap then skips port 0.
  function automatic logic [GW-1:0] ptr_after(input logic [GW-1:0] gnt,
                                              input logic [GW-1:0] ptr);
    logic [GW-1:0] nxt;
    if (PRIO_EN && gnt == '0)               nxt = ptr;
    else if (gnt == GW'(NUM_PORTS - 1))     nxt = PRIO_EN ? GW'(1) : '0;
    else                                    nxt = gnt + GW'(1);
    return nxt;
  endfunction

  logic [1:0]    rd_state, wr_state;
  logic [GW-1:0] rd_gnt, rd_ptr, wr_gnt, wr_ptr;

  // ---------------- read arbiter ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_state <= R_IDLE;
      rd_gnt   <= '0;
      rd_ptr   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: if (|s_arvalid_i) begin
          rd_gnt   <= rr_pick(s_arvalid_i, rd_ptr);
          rd_state <= R_ADDR;
        end
        R_ADDR: if (m_arready_i) rd_state <= R_DATA;
        R_DATA: if (m_rvalid_i && m_rready_o && m_rlast_i) begin
          rd_ptr   <= ptr_after(rd_gnt, rd_ptr);
          rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign m_arvalid_o = (rd_state == R_ADDR);
  assign m_araddr_o  = s_araddr_i[int'(rd_gnt)*ADDR_W +: ADDR_W];
  assign m_arid_o    = s_arid_i[int'(rd_gnt)*ID_W +: ID_W];
  assign m_arlen_o   = s_arlen_i[int'(rd_gnt)*8 +: 8];
  assign m_arburst_o = 2'b01;
  assign m_rready_o  = (rd_state == R_DATA) && s_rready_i[rd_gnt];
  assign s_rdata_o   = m_rdata_i;
  assign s_rresp_o   = m_rresp_i;
  assign s_rid_o     = m_rid_i;
  assign s_rlast_o   = m_rlast_i;

  always_comb begin
    s_arready_o = '0;
    s_rvalid_o  = '0;
    if (rd_state == R_ADDR) s_arready_o[rd_gnt] = m_arready_i;
    if (rd_state == R_DATA) s_rvalid_o[rd_gnt]  = m_rvalid_i;
  end

  // ---------------- write arbiter ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_state <= W_IDLE;
      wr_gnt   <= '0;
      wr_ptr   <= '0;
    end else begin
      case (wr_state)
        W_IDLE: if (|s_awvalid_i) begin
          wr_gnt   <= rr_pick(s_awvalid_i, wr_ptr);
          wr_state <= W_ADDR;
        end
        W_ADDR: if (m_awready_i) wr_state <= W_DATA;
        W_DATA: if (m_wvalid_o && m_wready_i && m_wlast_o) wr_state <= W_RESP;
        W_RESP: if (m_bvalid_i && m_bready_o) begin
          wr_ptr   <= ptr_after(wr_gnt, wr_ptr);
          wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign m_awvalid_o = (wr_state == W_ADDR);
  assign m_awaddr_o  = s_awaddr_i[int'(wr_gnt)*ADDR_W +: ADDR_W];
  assign m_awid_o    = s_awid_i[int'(wr_gnt)*ID_W +: ID_W];
  assign m_awlen_o   = s_awlen_i[int'(wr_gnt)*8 +: 8];
  assign m_awburst_o = 2'b01;
  // W is only accepted after the AW of the same burst, so early W is held off.
  assign m_wvalid_o  = (wr_state == W_DATA) && s_wvalid_i[wr_gnt];
  assign m_wdata_o   = s_wdata_i[int'(wr_gnt)*DATA_W +: DATA_W];
  assign m_wstrb_o   = s_wstrb_i[int'(wr_gnt)*STRB_W +: STRB_W];
  assign m_wlast_o   = s_wlast_i[wr_gnt];
  assign m_bready_o  = (wr_state == W_RESP) && s_bready_i[wr_gnt];
  assign s_bresp_o   = m_bresp_i;
  assign s_bid_o     = m_bid_i;

  always_comb begin
    s_awready_o = '0;
    s_wready_o  = '0;
    s_bvalid_o  = '0;
    if (wr_state == W_ADDR) s_awready_o[wr_gnt] = m_awready_i;
    if (wr_state == W_DATA) s_wready_o[wr_gnt]  = m_wready_i;
    if (wr_state == W_RESP) s_bvalid_o[wr_gnt]  = m_bvalid_i;
  end

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
// Directed bench for sdram_axi_arbiter (4 ports, 32-bit addr/data, 4-bit ID).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_sdram_axi_arbiter;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   s_awvalid_i, s_awready_o, s_wvalid_i, s_wready_o, s_wlast_i, s_bvalid_o, s_bready_i;
  logic [3:0]   s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i;
  logic [127:0] s_awaddr_i, s_araddr_i, s_wdata_i;
  logic [15:0]  s_awid_i, s_arid_i, s_wstrb_i;
  logic [31:0]  s_awlen_i, s_arlen_i;
  logic [1:0]   s_bresp_o, s_rresp_o;
  logic [3:0]   s_bid_o, s_rid_o;
  logic [31:0]  s_rdata_o;
  logic         s_rlast_o;
  logic         m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i, m_wlast_o, m_bvalid_i, m_bready_o;
  logic         m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o, m_rlast_i;
  logic [31:0]  m_awaddr_o, m_araddr_o, m_wdata_o, m_rdata_i;
  logic [3:0]   m_awid_o, m_arid_o, m_wstrb_o, m_bid_i, m_rid_i;
  logic [7:0]   m_awlen_o, m_arlen_o;
  logic [1:0]   m_awburst_o, m_arburst_o, m_bresp_i, m_rresp_i;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  sdram_axi_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
    .s_awid_i(s_awid_i), .s_awlen_i(s_awlen_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wdata_i(s_wdata_i),
    .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o), .s_bid_o(s_bid_o),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_araddr_i(s_araddr_i),
    .s_arid_i(s_arid_i), .s_arlen_i(s_arlen_i),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i), .s_rdata_o(s_rdata_o),
    .s_rresp_o(s_rresp_o), .s_rid_o(s_rid_o), .s_rlast_o(s_rlast_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
    .m_awid_o(m_awid_o), .m_awlen_o(m_awlen_o), .m_awburst_o(m_awburst_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i), .m_bid_i(m_bid_i),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i),
    .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rlast_i(m_rlast_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One read burst for port g, whose arvalid the caller has raised while the read side is idle.
  task automatic rd_burst(input int g, input int beats);
    tick();
    m_arready_i = 1'b1;
    #1;
    chk("ar_grant", s_arready_o, 64'(1 << g));
    tick();
    s_arvalid_i[g] = 1'b0;
    m_arready_i    = 1'b0;
    s_rready_i     = 4'hF;
    for (int b = 0; b < beats; b++) begin
      m_rvalid_i = 1'b1;
      m_rlast_i  = (b == beats - 1);
      m_rdata_i  = 32'hA000_0000 + 32'(b);
      #1;
      chk("r_route", s_rvalid_o, 64'(1 << g));
      chk("r_data", s_rdata_o, 64'(32'hA000_0000 + 32'(b)));
      tick();
    end
    m_rvalid_i = 1'b0;
    m_rlast_i  = 1'b0;
    s_rready_i = 4'h0;
  endtask

  initial begin
    rst_i = 1'b0;
    s_awvalid_i = '0; s_awaddr_i = '0; s_awid_i = '0; s_awlen_i = '0;
    s_wvalid_i = '0; s_wdata_i = '0; s_wstrb_i = '0; s_wlast_i = '0; s_bready_i = '0;
    s_arvalid_i = '0; s_araddr_i = '0; s_arid_i = '0; s_arlen_i = '0; s_rready_i = '0;
    m_awready_i = 1'b0; m_wready_i = 1'b0; m_bvalid_i = 1'b0; m_bresp_i = '0; m_bid_i = '0;
    m_arready_i = 1'b0; m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; m_rid_i = '0;
    m_rlast_i = 1'b0;

    // Reset state
    #2;
    chk("rst_arvalid", m_arvalid_o, 0);
    chk("rst_awvalid", m_awvalid_o, 0);
    chk("rst_s_ready", {s_arready_o, s_awready_o, s_wready_o}, 0);
    chk("rst_s_valid", {s_rvalid_o, s_bvalid_o}, 0);
    chk("rst_m_ready", {m_rready_o, m_bready_o, m_wvalid_o}, 0);
    tick();
    rst_i = 1'b1;

    // Port 2 alone: AR 0x100 len 3, four beats routed to port 2 only
    s_araddr_i[64 +: 32] = 32'h100;
    s_arlen_i[16 +: 8]   = 8'd3;
    s_arid_i[8 +: 4]     = 4'h5;
    s_arvalid_i          = 4'b0100;
    #1;
    chk("t1_arb_latency", m_arvalid_o, 0);
    tick();
    m_arready_i = 1'b1;
    #1;
    chk("t1_arvalid", m_arvalid_o, 1);
    chk("t1_araddr", m_araddr_o, 32'h100);
    chk("t1_arlen", m_arlen_o, 8'd3);
    chk("t1_arid", m_arid_o, 4'h5);
    chk("t1_arburst", m_arburst_o, 2'b01);
    chk("t1_arready", s_arready_o, 4'b0100);
    tick();
    s_arvalid_i = '0;
    m_arready_i = 1'b0;
    s_rready_i  = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      m_rvalid_i = 1'b1;
      m_rlast_i  = (b == 3);
      m_rdata_i  = 32'h1000 + 32'(b);
      #1;
      chk("t1_rvalid", s_rvalid_o, 4'b0100);
      chk("t1_rready", m_rready_o, 1);
      chk("t1_rdata", s_rdata_o, 32'h1000 + 32'(b));
      chk("t1_rlast", s_rlast_o, (b == 3) ? 1 : 0);
      tick();
    end
    #1;
    chk("t1_idle_no_route", s_rvalid_o, 0);
    m_rvalid_i = 1'b0;
    m_rlast_i  = 1'b0;
    s_rready_i = '0;

    // Ports 0,1,3 together from reset: order 0,1,3, then wrap to 0
    rst_i = 1'b0;
    #1;
    rst_i = 1'b1;
    s_arvalid_i = 4'b1011;
    rd_burst(0, 1);
    rd_burst(1, 1);
    rd_burst(3, 1);
    s_arvalid_i = 4'b1011;
    rd_burst(0, 2);
    s_arvalid_i = '0;

    // Port 1 write, two beats; port 0 pushes W without AW and must be held off
    s_awaddr_i[32 +: 32] = 32'h200;
    s_awlen_i[8 +: 8]    = 8'd1;
    s_awid_i[4 +: 4]     = 4'h3;
    s_awvalid_i          = 4'b0010;
    s_wvalid_i           = 4'b0011;
    s_wdata_i[32 +: 32]  = 32'hDEADBEEF;
    s_wdata_i[0 +: 32]   = 32'h1111_1111;
    s_wstrb_i            = 16'hFFFF;
    m_wready_i           = 1'b1;
    #1;
    chk("t3_idle_wready", s_wready_o, 0);
    tick();
    m_awready_i = 1'b1;
    #1;
    chk("t3_awvalid", m_awvalid_o, 1);
    chk("t3_awaddr", m_awaddr_o, 32'h200);
    chk("t3_awlen", m_awlen_o, 8'd1);
    chk("t3_awready", s_awready_o, 4'b0010);
    chk("t3_w_before_aw", s_wready_o, 0);
    tick();
    s_awvalid_i = '0;
    m_awready_i = 1'b0;
    #1;
    chk("t3_wvalid", m_wvalid_o, 1);
    chk("t3_wdata0", m_wdata_o, 32'hDEADBEEF);
    chk("t3_wready_p1only", s_wready_o, 4'b0010);
    chk("t3_wlast0", m_wlast_o, 0);
    tick();
    s_wdata_i[32 +: 32] = 32'hCAFEF00D;
    s_wlast_i           = 4'b0010;
    #1;
    chk("t3_wdata1", m_wdata_o, 32'hCAFEF00D);
    chk("t3_wlast1", m_wlast_o, 1);
    tick();
    s_wvalid_i = '0;
    s_wlast_i  = '0;
    m_wready_i = 1'b0;
    m_bvalid_i = 1'b1;
    m_bid_i    = 4'h3;
    s_bready_i = 4'b0010;
    #1;
    chk("t3_bvalid", s_bvalid_o, 4'b0010);
    chk("t3_bid", s_bid_o, 4'h3);
    chk("t3_bready", m_bready_o, 1);
    tick();
    #1;
    chk("t3_b_done", s_bvalid_o, 0);
    m_bvalid_i = 1'b0;
    s_bready_i = '0;

    // Concurrent read on port 0 and single-beat write on port 3
    s_araddr_i[0 +: 32]  = 32'h300;
    s_arvalid_i          = 4'b0001;
    s_awaddr_i[96 +: 32] = 32'h400;
    s_awlen_i[24 +: 8]   = 8'd0;
    s_awvalid_i          = 4'b1000;
    s_wvalid_i           = 4'b1000;
    s_wdata_i[96 +: 32]  = 32'h1234_5678;
    s_wlast_i            = 4'b1000;
    tick();
    m_arready_i = 1'b1;
    m_awready_i = 1'b1;
    #1;
    chk("t4_arready", s_arready_o, 4'b0001);
    chk("t4_awready", s_awready_o, 4'b1000);
    chk("t4_araddr", m_araddr_o, 32'h300);
    chk("t4_awaddr", m_awaddr_o, 32'h400);
    tick();
    s_arvalid_i = '0;
    s_awvalid_i = '0;
    m_arready_i = 1'b0;
    m_awready_i = 1'b0;
    m_rvalid_i  = 1'b1;
    m_rlast_i   = 1'b1;
    m_rdata_i   = 32'h55AA_55AA;
    s_rready_i  = 4'hF;
    m_wready_i  = 1'b1;
    #1;
    chk("t4_rvalid", s_rvalid_o, 4'b0001);
    chk("t4_wready", s_wready_o, 4'b1000);
    chk("t4_wdata", m_wdata_o, 32'h1234_5678);
    tick();
    s_wvalid_i = '0;
    s_wlast_i  = '0;
    m_wready_i = 1'b0;
    m_bvalid_i = 1'b1;
    m_bid_i    = 4'h7;
    s_bready_i = 4'hF;
    #1;
    chk("t4_bvalid", s_bvalid_o, 4'b1000);
    chk("t4_bid", s_bid_o, 4'h7);
    chk("t4_r_idle_no_route", s_rvalid_o, 0);
    tick();
    m_bvalid_i = 1'b0;
    m_rvalid_i = 1'b0;
    m_rlast_i  = 1'b0;
    s_bready_i = '0;
    // Pointers now differ per direction: read resumes at 1, write at 0
    s_arvalid_i = 4'b1010;
    s_awvalid_i = 4'b0101;
    tick();
    m_arready_i = 1'b1;
    m_awready_i = 1'b1;
    #1;
    chk("t4_rd_ptr", s_arready_o, 4'b0010);
    chk("t4_wr_ptr", s_awready_o, 4'b0001);
    tick();
    s_arvalid_i = '0;
    s_awvalid_i = '0;
    m_arready_i = 1'b0;
    m_awready_i = 1'b0;
    s_wvalid_i  = 4'b0001;
    m_wready_i  = 1'b1;
    m_rvalid_i  = 1'b1;
    m_rlast_i   = 1'b0;
    s_rready_i  = 4'hF;
    #1;
    chk("t5_beat1", s_rvalid_o, 4'b0010);
    tick();
    #1;
    chk("t5_beat2", s_rvalid_o, 4'b0010);
    chk("t5_wvalid", m_wvalid_o, 1);

    // Reset during read beat 2: everything drops in the same cycle
    rst_i = 1'b0;
    #1;
    chk("t5_rst_rvalid", s_rvalid_o, 0);
    chk("t5_rst_rready", m_rready_o, 0);
    chk("t5_rst_wvalid", m_wvalid_o, 0);
    chk("t5_rst_wready", s_wready_o, 0);
    m_rvalid_i  = 1'b0;
    s_wvalid_i  = '0;
    m_wready_i  = 1'b0;
    s_rready_i  = '0;
    s_arvalid_i = 4'b1001;
    rst_i       = 1'b1;
    tick();
    m_arready_i = 1'b1;
    #1;
    chk("t5_post_rst_grant", s_arready_o, 4'b0001);
    tick();
    s_arvalid_i = '0;
    m_arready_i = 1'b0;
    m_rvalid_i  = 1'b1;
    m_rlast_i   = 1'b1;
    s_rready_i  = 4'hF;
    #1;
    chk("t5_post_rst_r", s_rvalid_o, 4'b0001);
    tick();
    m_rvalid_i = 1'b0;
    m_rlast_i  = 1'b0;
    s_rready_i = '0;

    // Move the read pointer to 2, then ports 0 and 2 compete
    s_arvalid_i = 4'b0010;
    rd_burst(1, 1);
    s_arvalid_i = 4'b0101;
`ifdef SDRAM_ARB_PRIO_EN
    rd_burst(0, 1);
    rd_burst(2, 1);
`else
    rd_burst(2, 1);
    rd_burst(0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
